alu_op_sequencer: RTL and testbench

Initiator-side driver for the 32-bit multi-function ALU. It accepts operation requests over a valid/ready handshake and drives the ALU's A, B, select and rst inputs. For the multi-cycle mod operation it restarts the ALU's internal mod engine and waits a fixed latency before sampling R. The captured result is returned over a valid/ready response channel, so upstream logic never has to know per-op ALU timing.

---
 rtl/alu_op_sequencer_if.sv | 31 +++
 rtl/alu_op_sequencer.sv | 158 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer_if
// Request/response channels between an upstream client and alu_op_sequencer.
//   req: valid/ready handshake carrying operands and op code (client -> seq)
//   rsp: valid/ready handshake carrying captured result and op (seq -> client)
// master = client side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface alu_op_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [2:0]       req_op;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [2:0]       rsp_op;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_op
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_op
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Initiator-side driver for the 32-bit multi-function ALU. Accepts one op at a
// time over bus.req, drives the ALU inputs, waits the op-dependent latency
// (one cycle for combinational ops, a restart pulse plus MOD_LATENCY cycles for
// mod) and returns the sampled ALU result over bus.rsp.
//
// Optional feature macro: ALU_SEQ_STATS_EN
//   When defined, adds stat_ops / stat_mods handshake counters.
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int WIDTH       = 32,
    parameter int MOD_LATENCY = 40,  // >= 1
    parameter int CNT_W       = 6    // 2**CNT_W > MOD_LATENCY
) (
    input  logic               clk,
    input  logic               rst,
    alu_op_sequencer_if.slave  bus,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [2:0]         alu_select,
    output logic               alu_rst,
    input  logic [WIDTH-1:0]   alu_r
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [31:0]        stat_ops,
    output logic [31:0]        stat_mods
`endif
);

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_NOR = 3'b011,
        OP_LT  = 3'b100,
        OP_ADD = 3'b101,
        OP_SUB = 3'b110,
        OP_MOD = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MOD_RST,
        S_MOD_WAIT,
        S_RESP
    } state_e;

    state_e             state;
    logic               req_ready_q;
    logic               rsp_valid_q;
    logic [WIDTH-1:0]   rsp_result_q;
    logic [2:0]         rsp_op_q;
    logic [CNT_W-1:0]   wait_cnt;

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_op     = rsp_op_q;

    // ALU restart: any system reset, plus the single MOD_RST cycle.
    assign alu_rst = rst || (state == S_MOD_RST);

    // Sequencer FSM with registered handshake outputs and ALU operand registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is just the highest-priority branch
        // of the clocked block rather than part of the sensitivity list.
        if (rst) begin
            state        <= S_IDLE;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_op_q     <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_select   <= '0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // req_ready is registered: after a response it comes back
                    // one cycle late, which gives a single bubble in IDLE.
                    if (bus.req_valid && req_ready_q) begin
                        alu_a       <= bus.req_a;
                        alu_b       <= bus.req_b;
                        alu_select  <= bus.req_op;
                        req_ready_q <= 1'b0;
                        state       <= (bus.req_op == OP_MOD) ? S_MOD_RST : S_EXEC;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end

                S_EXEC: begin
                    // Combinational ops have settled one cycle after the
                    // operand registers loaded.
                    rsp_result_q <= alu_r;
                    rsp_op_q     <= alu_select;
                    rsp_valid_q  <= 1'b1;
                    state        <= S_RESP;
                end

                S_MOD_RST: begin
                    wait_cnt <= CNT_W'(MOD_LATENCY - 1);
                    state    <= S_MOD_WAIT;
                end

                S_MOD_WAIT: begin
                    if (wait_cnt == '0) begin
                        rsp_result_q <= alu_r;
                        rsp_op_q     <= alu_select;
                        rsp_valid_q  <= 1'b1;
                        state        <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                S_RESP: begin
                    // Result and ALU inputs hold for as long as the consumer
                    // applies backpressure.
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state       <= S_IDLE;
                    req_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic rsp_fire;
    assign rsp_fire = rsp_valid_q && bus.rsp_ready;

    // Response handshake counters; wrap naturally at 2**32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops  <= '0;
            stat_mods <= '0;
        end else if (rsp_fire) begin
            stat_ops <= stat_ops + 32'd1;
            if (rsp_op_q == OP_MOD) begin
                stat_mods <= stat_mods + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
// Self-checking bench: directed cases plus randomized ops against a
// transaction-level model (expected result, latency, restart pulse, hold and
// bubble behaviour). A behavioural ALU with a delayed mod engine drives alu_r.
// Build with +define+ALU_SEQ_STATS_EN to also check the statistics counters.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

    localparam int WIDTH       = 32;
    localparam int MOD_LATENCY = 40;
    localparam int CNT_W       = 6;
    localparam logic [2:0] OPC_MOD = 3'b111;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.WIDTH(WIDTH)) bus ();

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_r;
    logic [2:0]       alu_select;
    logic             alu_rst;
`ifdef ALU_SEQ_STATS_EN
    logic [31:0] stat_ops;
    logic [31:0] stat_mods;
`endif

    alu_op_sequencer #(
        .WIDTH       (WIDTH),
        .MOD_LATENCY (MOD_LATENCY),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_select (alu_select),
        .alu_rst    (alu_rst),
        .alu_r      (alu_r)
`ifdef ALU_SEQ_STATS_EN
        ,
        .stat_ops   (stat_ops),
        .stat_mods  (stat_mods)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int unsigned model_ops  = 0;
    int unsigned model_mods = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ALU function table as seen by a client.
    function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a ^ b;
            3'b011:  return ~(a | b);
            3'b100:  return (a < b) ? 32'd1 : 32'd0;
            3'b101:  return a + b;
            3'b110:  return a - b;
            default: return (b == 0) ? 32'hDEAD_BEEF : a % b;
        endcase
    endfunction

    // Behavioural ALU: the mod engine only presents a valid result once
    // MOD_LATENCY-1 cycles have passed since the cycle after its restart.
    int unsigned mod_age = 0;
    always @(posedge clk) begin
        if (alu_rst)               mod_age <= 0;
        else if (mod_age < 10000)  mod_age <= mod_age + 1;
    end

    always_comb begin
        alu_r = alu_fn(alu_select, alu_a, alu_b);
        if (alu_select == OPC_MOD && mod_age < MOD_LATENCY - 1) alu_r = 32'hBAD0_0BAD;
    end

    // One request/response transaction with full protocol checking.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int bp, input bit junk);
        int k, lat, rst_cnt, rst_first, exp_lat;
        bit ready_ok, hold_ok;
        logic [31:0] exp;
        exp     = alu_fn(op, a, b);
        exp_lat = (op == OPC_MOD) ? MOD_LATENCY + 2 : 2;

        k = 0;
        while (!bus.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);

        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_op    = op;
        bus.rsp_ready = (bp == 0);
        @(posedge clk);
        @(negedge clk);

        // Requests offered while busy must be ignored.
        bus.req_valid = junk;
        if (junk) begin
            bus.req_a  = $urandom;
            bus.req_b  = $urandom;
            bus.req_op = 3'($urandom_range(0, 7));
        end

        k = 1; lat = 0; rst_cnt = 0; rst_first = 0; ready_ok = 1'b1;
        while (lat == 0 && k < 200) begin
            if (alu_rst) begin
                rst_cnt++;
                if (rst_first == 0) rst_first = k;
            end
            if (bus.req_ready) ready_ok = 1'b0;
            if (bus.rsp_valid) lat = k;
            else begin
                @(negedge clk);
                k++;
            end
        end
        bus.req_valid = 1'b0;

        check("latency", 32'(lat), 32'(exp_lat));
        check("alu_rst_pulses", 32'(rst_cnt), (op == OPC_MOD) ? 32'd1 : 32'd0);
        if (op == OPC_MOD) check("alu_rst_cycle", 32'(rst_first), 32'd1);
        check("req_ready_busy", 32'(ready_ok), 32'd1);
        check("rsp_result", bus.rsp_result, exp);
        check("rsp_op", 32'(bus.rsp_op), 32'(op));
        check("alu_a", alu_a, a);
        check("alu_b", alu_b, b);
        check("alu_select", 32'(alu_select), 32'(op));

        hold_ok = 1'b1;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_result !== exp || bus.rsp_op !== op ||
                bus.req_ready || alu_a !== a || alu_b !== b || alu_select !== op)
                hold_ok = 1'b0;
        end
        if (bp > 0) check("backpressure_hold", 32'(hold_ok), 32'd1);
        bus.rsp_ready = 1'b1;

        @(negedge clk);
        check("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
        check("req_ready_bubble", 32'(bus.req_ready), 32'd0);
        bus.rsp_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("req_ready_return", 32'(bus.req_ready), 32'd1);

        model_ops++;
        if (op == OPC_MOD) model_mods++;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rsp_valid"},  32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_result"}, bus.rsp_result, 32'd0);
        check({tag, "_rsp_op"},     32'(bus.rsp_op), 32'd0);
        check({tag, "_alu_a"},      alu_a, 32'd0);
        check({tag, "_alu_b"},      alu_b, 32'd0);
        check({tag, "_alu_select"}, 32'(alu_select), 32'd0);
        check({tag, "_alu_rst"},    32'(alu_rst), 32'd1);
        check({tag, "_req_ready"},  32'(bus.req_ready), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [2:0]  op;
        logic [31:0] a, b;

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", 32'(bus.req_ready), 32'd1);
        check("post_reset_alu_rst", 32'(alu_rst), 32'd0);

        // Directed cases.
        run_op(3'b101, 32'd5, 32'd7, 0, 1'b0);
        run_op(3'b110, 32'd3, 32'd5, 0, 1'b1);
        run_op(3'b100, 32'd3, 32'd5, 0, 1'b0);
        run_op(3'b111, 32'd17, 32'd5, 0, 1'b1);
        run_op(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 10, 1'b1);
`ifdef ALU_SEQ_STATS_EN
        check("stat_ops", stat_ops, model_ops);
        check("stat_mods", stat_mods, model_mods);
`endif

        // Reset in the middle of a mod wait: op dropped, no response.
        while (!bus.req_ready) @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_a     = 32'd100;
        bus.req_b     = 32'd7;
        bus.req_op    = OPC_MOD;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midmod");
        rst = 1'b0;
        model_ops  = 0;
        model_mods = 0;
`ifdef ALU_SEQ_STATS_EN
        check("stat_ops_rst", stat_ops, 32'd0);
        check("stat_mods_rst", stat_mods, 32'd0);
`endif
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        check("dropped_no_rsp", 32'(seen), 32'd0);
        run_op(3'b010, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 30; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if (op == OPC_MOD) b = 32'($urandom_range(1, 1000));
            run_op(op, a, b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

`ifdef ALU_SEQ_STATS_EN
        check("stat_ops_end", stat_ops, model_ops);
        check("stat_mods_end", stat_mods, model_mods);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("stat_ops_clear", stat_ops, 32'd0);
        check("stat_mods_clear", stat_mods, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
